// File: rtl/sum_block_accum.sv
// Accumulates COUNT consecutive adder sums into one block total and holds it on a
// valid/ready output until it is taken. Define ACC_SAT_EN for saturating accumulation.
module sum_block_accum #(
   parameter int IN_W  = 5,
   parameter int ACC_W = 8,
   parameter int COUNT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data,
   output logic             out_ovf
);

   typedef enum logic {
      ACC  = 1'b0,
      DONE = 1'b1
   } state_t;

   localparam logic [7:0] LAST_CNT = 8'(COUNT - 1);

   state_t           state;
   state_t           state_nxt;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_nxt;
   logic [7:0]       cnt;
   logic             ovf;
   logic             carry;
   logic [ACC_W:0]   sum_ext;
   logic             accept;
   logic             transfer;
   logic             last;

   // One extra bit holds the carry out of the accumulator.
   assign sum_ext = {1'b0, acc} + (ACC_W+1)'(in_data);
   assign carry   = sum_ext[ACC_W];

`ifdef ACC_SAT_EN
   assign acc_nxt = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
   assign acc_nxt = sum_ext[ACC_W-1:0];
`endif

   assign accept   = in_valid & in_ready;
   assign transfer = out_valid & out_ready;
   assign last     = (cnt == LAST_CNT);

   always_ff @(posedge clk) begin
      if (rst) state <= ACC;
      else     state <= state_nxt;
   end

   // NOTE: every output of this block is given a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         ACC: begin
            in_ready = 1'b1;
            if (accept && last) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = ACC;
         end
         default: state_nxt = ACC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc      <= '0;
         cnt      <= '0;
         ovf      <= 1'b0;
         out_data <= '0;
         out_ovf  <= 1'b0;
      end else if (transfer) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (accept) begin
         acc <= acc_nxt;
         cnt <= cnt + 8'd1;
         ovf <= ovf | carry;
         if (last) begin
            out_data <= acc_nxt;
            out_ovf  <= ovf | carry;
         end
      end
   end

endmodule
